// File: rtl/rv4028_bus_target.sv
// rv4028_bus_target
//   Target (responder) for the RV4028 16-bit external bus. A combinational
//   window decode selects this instance. Reads come from an internal word RAM.
//   After a programmable number of wait states the read word is presented for
//   one data-phase cycle. Writes are byte-masked and take one data-phase cycle.
//
// Parameters
//   BASE_ADDR   window base, aligned to 2^(ADDR_BITS+1) bytes
//   ADDR_BITS   word-address bits (RAM depth 2^ADDR_BITS x 16)
//   WAIT_STATES read wait states, 0..15
//   IO_SPACE    1: respond when iorq_n=0, 0: respond when iorq_n=1
//
// Ports
//   clk, rst_n  clock, synchronous active-low reset
//   addr        byte address (bit 0 ignored)
//   rd_n        read request, active low
//   wr_n[1:0]   write strobes, active low (write when either is low)
//   msk_n[1:0]  byte lanes, active low ([0]=data[7:0], [1]=data[15:8])
//   iorq_n      I/O space qualifier
//   mreq_n[1:0] cycle qualifiers (valid when not 2'b11)
//   data_in     write data
//   wait_n      low while read data is not ready
//   data_out    read data (holds last read value)
//   data_oe     high while this target drives read data
//   sel         combinational window hit
//
// Optional feature (macro RV4028_BUS_TARGET_WPROT_EN)
//   Adds input wprot and output wr_err. A write data phase with wprot=1 leaves
//   the RAM unchanged. It sets wr_err, which stays set until reset.

module rv4028_bus_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_STATES = 0,
  parameter int          IO_SPACE    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        rd_n,
  input  logic [1:0]  wr_n,
  input  logic [1:0]  msk_n,
  input  logic        iorq_n,
  input  logic [1:0]  mreq_n,
  input  logic [15:0] data_in,
`ifdef RV4028_BUS_TARGET_WPROT_EN
  input  logic        wprot,
  output logic        wr_err,
`endif
  output logic        wait_n,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        sel
);

  localparam int         DEPTH      = 1 << ADDR_BITS;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_RD_DATA = 2'd2;
  localparam logic [1:0] ST_WR_DATA = 2'd3;
  localparam logic       IORQ_HIT   = (IO_SPACE != 0) ? 1'b0 : 1'b1;
  // The counter is loaded with WAIT_STATES-1 so that RD_WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [3:0] WAIT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [15:0]          mem_r [DEPTH];
  logic [1:0]           state_r, state_nxt_s;
  logic [3:0]           cnt_r, cnt_nxt_s;
  logic [ADDR_BITS-1:0] idx_s, wr_idx_r;
  logic [1:0]           wr_msk_r;
  logic                 hit_s, rd_go_s, wr_go_s, wr_en_s;
  logic                 wait_n_r, data_oe_r;
  logic [15:0]          data_out_r;
  logic                 unused_s;

  assign unused_s = addr[0];
  assign idx_s    = addr[ADDR_BITS:1];
  assign hit_s    = (addr[31:ADDR_BITS+1] == BASE_ADDR[31:ADDR_BITS+1])
                  && (iorq_n == IORQ_HIT) && (mreq_n != 2'b11);
  assign sel      = hit_s;

  // If rd_n is also low during a write, this is a protocol error. The write
  // takes priority: rd_go_s requires wr_n to be idle.
  assign wr_go_s  = (state_r == ST_IDLE) && hit_s && (wr_n != 2'b11);
  assign rd_go_s  = (state_r == ST_IDLE) && hit_s && !rd_n && (wr_n == 2'b11);

`ifdef RV4028_BUS_TARGET_WPROT_EN
  assign wr_en_s  = (state_r == ST_WR_DATA) && !wprot;
`else
  assign wr_en_s  = (state_r == ST_WR_DATA);
`endif

  assign wait_n   = wait_n_r;
  assign data_oe  = data_oe_r;
  assign data_out = data_out_r;

  // Next-state and wait-counter logic for the access sequencer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_go_s) begin
          state_nxt_s = ST_WR_DATA;
        end else if (rd_go_s) begin
          if (WAIT_STATES > 0) begin
            state_nxt_s = ST_RD_WAIT;
            cnt_nxt_s   = WAIT_INIT;
          end else begin
            state_nxt_s = ST_RD_DATA;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_RD_DATA;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RD_DATA: state_nxt_s = ST_IDLE;
      ST_WR_DATA: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // State, registered bus outputs and latched write address/mask.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      wait_n_r   <= 1'b1;
      data_oe_r  <= 1'b0;
      data_out_r <= 16'h0000;
      wr_idx_r   <= '0;
      wr_msk_r   <= 2'b11;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      // The outputs follow the state being entered. They are therefore valid
      // in the same cycle as that state, without a combinational path.
      wait_n_r  <= (state_nxt_s != ST_RD_WAIT);
      data_oe_r <= (state_nxt_s == ST_RD_DATA);
      if (rd_go_s) begin
        data_out_r <= mem_r[idx_s];
      end
      if (wr_go_s) begin
        wr_idx_r <= idx_s;
        wr_msk_r <= msk_n;
      end
    end
  end

  // Word RAM write port. There is no reset. A write data phase that coincides
  // with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_s) begin
      if (!wr_msk_r[0]) begin
        mem_r[wr_idx_r][7:0] <= data_in[7:0];
      end
      if (!wr_msk_r[1]) begin
        mem_r[wr_idx_r][15:8] <= data_in[15:8];
      end
    end
  end

`ifdef RV4028_BUS_TARGET_WPROT_EN
  // Sticky flag for a write that was blocked by protection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else if ((state_r == ST_WR_DATA) && wprot) begin
      wr_err <= 1'b1;
    end else begin
      wr_err <= wr_err;
    end
  end
`endif

endmodule

// File: tb/tb_rv4028_bus_target.sv
// Bench for rv4028_bus_target: two targets share one bus.
//   t0: window 0x0000_0000, no wait states.
//   t1: window 0x0000_1000, three wait states.
// The stimulus pushes expected read responses into per-target queues.
// A negedge monitor pops an entry whenever data_oe is high and checks it.

module tb_rv4028_bus_target;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam int          WS0   = 0;
  localparam int          WS1   = 3;

  typedef struct packed {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        rd_n;
  logic [1:0]  wr_n;
  logic [1:0]  msk_n;
  logic        iorq_n;
  logic [1:0]  mreq_n;
  logic [15:0] data_in;
  logic        wn0, oe0, sel0, wn1, oe1, sel1;
  logic [15:0] do0, do1;

  logic [15:0] mdl [2][256];
  exp_t        q0[$];
  exp_t        q1[$];
  int          wlow [2];
  logic [15:0] last [2];
  int          ncyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  rv4028_bus_target #(.BASE_ADDR(BASE0), .ADDR_BITS(8), .WAIT_STATES(WS0), .IO_SPACE(0)) u_t0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_n(rd_n), .wr_n(wr_n), .msk_n(msk_n),
    .iorq_n(iorq_n), .mreq_n(mreq_n), .data_in(data_in),
    .wait_n(wn0), .data_out(do0), .data_oe(oe0), .sel(sel0));

  rv4028_bus_target #(.BASE_ADDR(BASE1), .ADDR_BITS(8), .WAIT_STATES(WS1), .IO_SPACE(0)) u_t1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_n(rd_n), .wr_n(wr_n), .msk_n(msk_n),
    .iorq_n(iorq_n), .mreq_n(mreq_n), .data_in(data_in),
    .wait_n(wn1), .data_out(do1), .data_oe(oe1), .sel(sel1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // Decode rule: the window matches on addr/512, memory space needs iorq_n=1,
  // and mreq_n must not be 2'b11.
  function automatic int tgt(input logic [31:0] a, input logic io, input logic [1:0] mq);
    if (mq == 2'b11 || io != 1'b1) return -1;
    if ((a >> 9) == (BASE0 >> 9)) return 0;
    if ((a >> 9) == (BASE1 >> 9)) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] rnd_act();
    return 2'($urandom_range(0, 2));
  endfunction

  task automatic bus_idle();
    addr   = 32'hFFFF_0000;
    rd_n   = 1'b1;
    wr_n   = 2'b11;
    msk_n  = 2'b11;
    iorq_n = 1'b1;
    mreq_n = 2'b11;
  endtask

  // All bus tasks start and end at posedge+1, with the targets in IDLE.
  task automatic rd(input logic [31:0] a, input bit keep);
    int   t;
    exp_t e;
    addr   = a;
    rd_n   = 1'b0;
    wr_n   = 2'b11;
    iorq_n = 1'b1;
    mreq_n = rnd_act();
    msk_n  = 2'($urandom_range(0, 3));
    t = tgt(a, 1'b1, mreq_n);
    if (t >= 0) begin
      e.data = mdl[t][a[8:1]];
      e.due  = ncyc + ((t == 0) ? WS0 : WS1) + 2;
      if (t == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    #1;
    chk("sel0_rd", {31'd0, sel0}, {31'd0, t == 0});
    chk("sel1_rd", {31'd0, sel1}, {31'd0, t == 1});
    @(posedge clk); #1;
    if (t >= 0) begin
      if (!keep) bus_idle();
      repeat (((t == 0) ? WS0 : WS1) + 1) @(posedge clk);
      #1;
    end
    if (!keep) bus_idle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [15:0] d, input logic [1:0] m,
                    input logic io, input logic [1:0] mq);
    int          t;
    logic [15:0] nv;
    addr    = a;
    data_in = d;
    msk_n   = m;
    iorq_n  = io;
    mreq_n  = mq;
    wr_n    = rnd_act();
    rd_n    = 1'($urandom_range(0, 1));
    t = tgt(a, io, mq);
    #1;
    chk("sel0_wr", {31'd0, sel0}, {31'd0, t == 0});
    chk("sel1_wr", {31'd0, sel1}, {31'd0, t == 1});
    @(posedge clk); #1;
    // During the data phase the mask input changes; the mask from the address phase applies.
    msk_n  = 2'($urandom_range(0, 3));
    mreq_n = 2'b11;
    wr_n   = 2'b11;
    rd_n   = 1'b1;
    addr   = 32'hFFFF_0000;
    if (t >= 0) begin
      @(posedge clk); #1;
      nv = mdl[t][a[8:1]];
      if (!m[0]) nv[7:0]  = d[7:0];
      if (!m[1]) nv[15:8] = d[15:8];
      mdl[t][a[8:1]] = nv;
    end
    bus_idle();
  endtask

  task automatic wr_ok(input logic [31:0] a, input logic [15:0] d, input logic [1:0] m);
    wr(a, d, m, 1'b1, rnd_act());
  endtask

  task automatic mon(input int d, input logic oe, input logic wn, input logic [15:0] dout);
    exp_t e;
    bit   empty;
    if (!rst_n) begin
      wlow[d] = 0;
      last[d] = 16'h0000;
      return;
    end
    if (!wn) wlow[d]++;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (oe) begin
      if (empty) begin
        chk($sformatf("unexpected_oe_t%0d", d), {31'd0, oe}, 32'd0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("rd_data_t%0d", d), {16'd0, dout}, {16'd0, e.data});
        chk($sformatf("rd_latency_t%0d", d), ncyc, e.due);
        chk($sformatf("wait_cycles_t%0d", d), wlow[d], (d == 0) ? WS0 : WS1);
        last[d] = e.data;
      end
      wlow[d] = 0;
    end else if (wn && empty) begin
      chk($sformatf("data_hold_t%0d", d), {16'd0, dout}, {16'd0, last[d]});
    end
  endtask

  // Monitor: check each target on the falling edge, away from the active edge.
  initial begin
    wlow[0] = 0; wlow[1] = 0;
    last[0] = 16'h0000; last[1] = 16'h0000;
    forever begin
      @(negedge clk);
      ncyc++;
      mon(0, oe0, wn0, do0);
      mon(1, oe1, wn1, do1);
    end
  end

  initial begin
    logic [31:0] a;
    logic [15:0] keep_val;
    int          k, d;

    rst_n   = 1'b0;
    data_in = 16'h0000;
    bus_idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wait_n0", {31'd0, wn0}, 32'd1);
    chk("rst_oe0",     {31'd0, oe0}, 32'd0);
    chk("rst_dout0",   {16'd0, do0}, 32'd0);
    chk("rst_wait_n1", {31'd0, wn1}, 32'd1);
    chk("rst_oe1",     {31'd0, oe1}, 32'd0);
    chk("rst_dout1",   {16'd0, do1}, 32'd0);
    @(posedge clk); #1;

    // Fill both RAMs so that every later read has a defined expected value.
    for (int w = 0; w < 256; w++) begin
      wr_ok(BASE0 + 32'(w * 2), 16'($urandom), 2'b00);
      wr_ok(BASE1 + 32'(w * 2), 16'($urandom), 2'b00);
    end

    // Basic write/read of word 3 on both targets.
    wr_ok(BASE0 + 32'h6, 16'hA55A, 2'b00);
    rd(BASE0 + 32'h6, 1'b0);
    wr_ok(BASE1 + 32'h6, 16'hA55A, 2'b00);
    rd(BASE1 + 32'h6, 1'b0);

    // Byte-lane writes to word 5.
    for (d = 0; d < 2; d++) begin
      a = (d == 0) ? BASE0 + 32'hA : BASE1 + 32'hA;
      wr_ok(a, 16'h1234, 2'b00);
      wr_ok(a, 16'hABCD, 2'b10);
      rd(a, 1'b0);
      wr_ok(a, 16'hEF00, 2'b01);
      rd(a, 1'b0);
    end
    chk("mask_model", {16'd0, mdl[0][5]}, 32'h0000_EFCD);

    // 32-bit access: two back-to-back 16-bit halves with rd_n held low.
    rd(BASE0 + 32'h10, 1'b1);
    rd(BASE0 + 32'h12, 1'b0);
    rd(BASE1 + 32'h10, 1'b1);
    rd(BASE1 + 32'h12, 1'b0);
    wr_ok(BASE0 + 32'h10, 16'h1111, 2'b00);
    wr_ok(BASE0 + 32'h12, 16'h2222, 2'b00);
    rd(BASE0 + 32'h10, 1'b1);
    rd(BASE0 + 32'h12, 1'b0);

    // Decode misses: none of these may write or respond.
    wr(32'h0000_0200, 16'hDEAD, 2'b00, 1'b1, 2'b00);
    wr(BASE0 + 32'h6, 16'hBEEF, 2'b00, 1'b0, 2'b00);
    wr(BASE0 + 32'h6, 16'hBEEF, 2'b00, 1'b1, 2'b11);
    wr(BASE1 + 32'h6, 16'hBEEF, 2'b00, 1'b0, 2'b10);
    rd(32'h0000_0200, 1'b0);
    rd(32'h0000_1206, 1'b0);
    rd(BASE0 + 32'h0, 1'b0);
    rd(BASE0 + 32'h6, 1'b0);
    rd(BASE1 + 32'h6, 1'b0);

    // Reset during the second wait cycle of a t1 read.
    addr = BASE1 + 32'h8; rd_n = 1'b0; wr_n = 2'b11; iorq_n = 1'b1; mreq_n = 2'b00;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstrd_wait_n1", {31'd0, wn1}, 32'd1);
    chk("rstrd_oe1",     {31'd0, oe1}, 32'd0);
    chk("rstrd_dout1",   {16'd0, do1}, 32'd0);
    @(posedge clk); #1;
    rd(BASE1 + 32'h8, 1'b0);

    // Reset during a write data phase: the RAM word keeps its value.
    keep_val = mdl[0][7];
    addr = BASE0 + 32'hE; data_in = ~keep_val; msk_n = 2'b00; wr_n = 2'b00;
    rd_n = 1'b1; iorq_n = 1'b1; mreq_n = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(BASE0 + 32'hE, 1'b0);

    // Random mix of reads, writes and decode misses.
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      d = $urandom_range(0, 1);
      a = ((d == 0) ? BASE0 : BASE1) + 32'($urandom_range(0, 255) * 2) + 32'($urandom_range(0, 1));
      case (k)
        0, 1, 2, 3: rd(a, 1'b0);
        4, 5, 6, 7: wr_ok(a, 16'($urandom), 2'($urandom_range(0, 3)));
        8: begin
          case ($urandom_range(0, 2))
            0:       wr(32'h0000_0200 + 32'($urandom_range(0, 32'hDFF)), 16'($urandom), 2'b00, 1'b1, 2'b00);
            1:       wr(a, 16'($urandom), 2'b00, 1'b0, rnd_act());
            default: wr(a, 16'($urandom), 2'b00, 1'b1, 2'b11);
          endcase
        end
        default: rd(32'h0000_0200 + 32'($urandom_range(0, 32'hDFF)), 1'b0);
      endcase
    end

    repeat (10) @(posedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
